serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder step per cycle, LSB first, result on done.
// Optional signed-overflow output ovf is enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   soma
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_soma;

    logic w_sumBit;
    logic w_carryNext;
    logic w_lastBit;
    logic w_accept;

    assign w_sumBit    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carryNext = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_lastBit   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept    = start && (r_state != ADD);

    assign busy = (r_state == ADD);
    assign done = (r_state == DONE);
    assign soma = r_soma;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ADD;
            ADD:     if (w_lastBit) w_next = DONE;
            DONE:    w_next = start ? ADD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operands shift right so bit 0 is always the bit being added; sum bits enter from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_soma  <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ADD) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= {w_sumBit, r_sum[WIDTH-1:1]};
            r_carry <= w_carryNext;
            r_cnt   <= r_cnt + CW'(1);
            if (w_lastBit) begin
                r_soma <= {w_carryNext, w_sumBit, r_sum[WIDTH-1:1]};
            end
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic r_ovf;

    // On the MSB step r_carry is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (!w_accept && (r_state == ADD) && w_lastBit) begin
            r_ovf <= r_carry ^ w_carryNext;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4): vector table, corner sequences,
// random and exhaustive operand checks against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W:0]   soma;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .soma  (soma)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W:0]   expSoma;
        logic         expOvf;
    } vec_t;

    function automatic logic [W:0] refSum(input logic [W-1:0] x, input logic [W-1:0] y);
        int s;
        s = int'(x) + int'(y);
        return s[W:0];
    endfunction

    function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        int s;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        s  = sx + sy;
        return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full operation: start for one cycle, scramble operands, watch busy/done until completion.
    task automatic applyStimulus(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic [W:0] expSoma, input logic expOvf);
        int lat;
        int busyCnt;
        int both;
        @(negedge clk);
        a = ta;
        b = tb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        busyCnt = 0;
        both = 0;
        while (1) begin
            if (busy) busyCnt++;
            if (busy && done) both = 1;
            if (done || lat >= 20) break;
            @(negedge clk);
            lat++;
        end
        checkOutput({name, " latency"}, lat, W);
        checkOutput({name, " busyCycles"}, busyCnt, W);
        checkOutput({name, " busyAndDone"}, both, 0);
        checkOutput({name, " soma"}, int'(soma), int'(expSoma));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        checkOutput({name, " ovf"}, int'(ovf), int'(expOvf));
`else
        if (expOvf === 1'bx) $display("[TB] unexpected unknown overflow expectation");
`endif
    endtask

    initial begin
        vec_t vecs[4];
        int doneCnt;
        int capt;
        int firstIdx;
        int secondIdx;
        int capt1;
        int capt2;
        int waited;

        vecs[0] = '{va: 4'd7,  vb: 4'd1,  expSoma: 5'b01000, expOvf: 1'b1};
        vecs[1] = '{va: 4'd15, vb: 4'd15, expSoma: 5'b11110, expOvf: 1'b0};
        vecs[2] = '{va: 4'd0,  vb: 4'd0,  expSoma: 5'b00000, expOvf: 1'b0};
        vecs[3] = '{va: 4'd8,  vb: 4'd8,  expSoma: 5'b10000, expOvf: 1'b1};

        // Reset with start held high: nothing may start until reset releases.
        rst_n = 1'b0;
        start = 1'b1;
        a = 4'd7;
        b = 4'd1;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset soma", int'(soma), 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        checkOutput("reset ovf", int'(ovf), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("first edge accept busy", int'(busy), 1);
        start = 1'b0;
        waited = 0;
        while (!done && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("post-reset op done seen", int'(done), 1);
        checkOutput("post-reset op soma", int'(soma), 8);

        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].expSoma, vecs[i].expOvf);
        end

        // Start re-asserted with new operands during ADD must be ignored.
        @(negedge clk);
        a = 4'd3;
        b = 4'd3;
        start = 1'b1;
        doneCnt = 0;
        capt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i <= 2) begin
                start = 1'b1;
                a = 4'd9;
                b = 4'd9;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                doneCnt++;
                capt = int'(soma);
            end
        end
        checkOutput("ignore start doneCount", doneCnt, 1);
        checkOutput("ignore start soma", capt, 6);

        // Start held continuously: back-to-back results one per WIDTH+1 cycles.
        @(negedge clk);
        a = 4'd2;
        b = 4'd2;
        start = 1'b1;
        doneCnt = 0;
        firstIdx = -1;
        secondIdx = -1;
        capt1 = -1;
        capt2 = -1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a = 4'd12;
                b = 4'd4;
            end
            if (done) begin
                doneCnt++;
                if (doneCnt == 1) begin
                    firstIdx = i;
                    capt1 = int'(soma);
                end else if (doneCnt == 2) begin
                    secondIdx = i;
                    capt2 = int'(soma);
                    start = 1'b0;
                end
            end
        end
        checkOutput("b2b doneCount", doneCnt, 2);
        checkOutput("b2b spacing", secondIdx - firstIdx, W + 1);
        checkOutput("b2b soma1", capt1, 4);
        checkOutput("b2b soma2", capt2, 16);

        // Reset during the second ADD cycle aborts the operation silently.
        @(negedge clk);
        a = 4'd5;
        b = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort soma", int'(soma), 0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("abort no done", doneCnt, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            applyStimulus($sformatf("rand a=%0d b=%0d", ra, rb), ra, rb, refSum(ra, rb), refOvf(ra, rb));
        end

        for (int x = 0; x < (1 << W); x++) begin
            for (int y = 0; y < (1 << W); y++) begin
                applyStimulus($sformatf("sweep a=%0d b=%0d", x, y), W'(x), W'(y),
                              refSum(W'(x), W'(y)), refOvf(W'(x), W'(y)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
